// File: rtl/pipeline_sequencer.sv
// Instruction pipe registers (Fetch, RF Read, Execute, Writeback) with the per-cycle
// advance / hold / freeze schedule, branch wait FSM and performance counters.
module pipeline_sequencer #(
    parameter int CNT_W  = 32,
    parameter int BR_BIT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_valid,
    input  logic [15:0]          fetch_inst,
    input  logic                 hazard_hold,
    input  logic                 mem_busy,
    input  logic                 br_taken,
    input  logic                 cnt_clr,
    output logic [4:1][15:0]     inst_ipipe,
    output logic [3:0]           valid_ipipe,
    output logic                 pc_enable,
    output logic                 br_resolve,
    output logic [CNT_W-1:0]     retired_cnt,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     branch_cnt
);

    // state     | meaning
    // ST_RUN    | stage 1 accepts fetched instructions
    // ST_BR_WAIT| branch between RF Read and Execute; stage 1 takes bubbles
    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_BR_WAIT = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [4:1][15:0]    inst_q, inst_d;
    logic [4:1]          valid_q, valid_d;
    logic [CNT_W-1:0]    retired_q, retired_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic [CNT_W-1:0]    branch_q, branch_d;

    logic freeze, hold, advance, br_res_raw, br_enter;

    // Fetch redirect direction is handled by the fetch unit itself.
    logic unused_br_taken;
    assign unused_br_taken = br_taken;

    always_comb begin
        freeze     = mem_busy;
        hold       = !freeze && hazard_hold && valid_q[2];
        advance    = !freeze && !hold;
        br_res_raw = !freeze && valid_q[3] && inst_q[3][BR_BIT];
        br_enter   = advance && (state_q == ST_RUN) && valid_q[1] && inst_q[1][BR_BIT];

        inst_d  = inst_q;
        valid_d = valid_q;
        state_d = state_q;

        if (hold) begin
            inst_d[4]  = inst_q[3];
            valid_d[4] = valid_q[3];
            inst_d[3]  = 16'h0000;
            valid_d[3] = 1'b0;
        end else if (advance) begin
            inst_d[4]  = inst_q[3];
            valid_d[4] = valid_q[3];
            inst_d[3]  = inst_q[2];
            valid_d[3] = valid_q[2];
            inst_d[2]  = inst_q[1];
            valid_d[2] = valid_q[1];
            // The word behind a newly detected branch is squashed.
            if ((state_q == ST_RUN) && !br_enter) begin
                inst_d[1]  = fetch_inst;
                valid_d[1] = fetch_valid;
            end else begin
                inst_d[1]  = 16'h0000;
                valid_d[1] = 1'b0;
            end
        end

        if (br_enter) begin
            state_d = ST_BR_WAIT;
        end else if (br_res_raw) begin
            state_d = ST_RUN;
        end
    end

    always_comb begin
        retired_d = retired_q;
        stall_d   = stall_q;
        branch_d  = branch_q;
        if (cnt_clr) begin
            retired_d = '0;
            stall_d   = '0;
            branch_d  = '0;
        end else begin
            if (valid_q[4] && !freeze) retired_d = retired_q + CNT_W'(1);
            if (freeze || hold)        stall_d   = stall_q + CNT_W'(1);
            if (br_res_raw)            branch_d  = branch_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            inst_q    <= '0;
            valid_q   <= '0;
            retired_q <= '0;
            stall_q   <= '0;
            branch_q  <= '0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            valid_q   <= valid_d;
            retired_q <= retired_d;
            stall_q   <= stall_d;
            branch_q  <= branch_d;
        end
    end

    assign inst_ipipe  = inst_q;
    assign valid_ipipe = valid_q;
    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;
    assign branch_cnt  = branch_q;
    assign br_resolve  = reset && br_res_raw;
    assign pc_enable   = reset && (((state_q == ST_RUN) && advance) || br_res_raw);

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
Owns the four instruction pipe registers (Fetch, RF Read, Execute, Writeback) of the 16-bit pipelined CPU and decides every cycle whether each stage advances, holds or takes a bubble. Combines data-memory back-pressure, the decode hazard hold and branch resolution into a single advance/stall/flush schedule. Drives pc_enable for the fetch unit and keeps retired/stall/branch performance counters. Sits between instruction memory and the per-stage decoder, which consumes inst_ipipe.

Parameters:
CNT_W, 32, width of each performance counter
BR_BIT, 3, opcode bit (inst[4:0]) that marks a branch instruction

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
fetch_valid  in  1  fetch_inst carries a real instruction this cycle
fetch_inst  in  16  instruction word from instruction memory
hazard_hold  in  1  RF-Read instruction depends on Writeback result; hold it
mem_busy  in  1  data memory not ready; freeze the whole pipe
br_taken  in  1  branch in Execute is taken; valid only when br_resolve=1
cnt_clr  in  1  synchronous clear of all counters
inst_ipipe  out  4x16  instruction word per stage, index 1..4
valid_ipipe  out  4  per-stage valid bit, bit n-1 = stage n
pc_enable  out  1  fetch unit may advance PC / redirect
br_resolve  out  1  branch in Execute resolves this cycle
retired_cnt  out  CNT_W  instructions that left Writeback
stall_cnt  out  CNT_W  cycles with freeze or hold
branch_cnt  out  CNT_W  branches resolved

Behaviour:
- Bubble = inst 16'h0000 with valid 0; every stage entering a bubble loads both.
- Reset (reset=0, async): all inst_ipipe 0, valid_ipipe 0, FSM=RUN, counters 0; pc_enable, br_resolve 0 while reset asserted.
- Per-cycle action, strict priority:
  1 FREEZE: mem_busy=1 -> no stage register changes, pc_enable=0, br_resolve=0.
  2 HOLD: hazard_hold=1 and stage 2 valid -> stages 1,2 hold; stage 3 loads bubble; stage 3 -> 4 advances; pc_enable=0.
  3 ADVANCE: 3->4, 2->3, 1->2; stage 1 loads fetch_inst/fetch_valid in RUN, bubble in BR_WAIT.
- hazard_hold with stage 2 invalid is ignored (ADVANCE).
- FSM states RUN, BR_WAIT:
  RUN -> BR_WAIT when ADVANCE moves a valid instruction with inst[BR_BIT]=1 from stage 1 into stage 2.
  BR_WAIT: stage 1 loads bubbles; pc_enable=0.
  br_resolve = 1 (combinational) when stage 3 valid, inst_ipipe[3][BR_BIT]=1, not FREEZE.
  BR_WAIT -> RUN on that cycle; pc_enable=1 that cycle so fetch redirects (br_taken) or falls through.
  Instruction in stage 1 during RUN->BR_WAIT transition is squashed: stage 1 loads bubble.
- pc_enable = (FSM=RUN) and not FREEZE and not HOLD, or br_resolve as above.
- A branch stays in stage 3 across FREEZE; br_resolve deasserts and reasserts when freeze drops; FSM stays BR_WAIT.
- Counters, mod 2^CNT_W (wrap silently from all-ones to 0):
  retired_cnt +1 when stage 4 valid and not FREEZE.
  stall_cnt +1 on every FREEZE or HOLD cycle.
  branch_cnt +1 when br_resolve=1.
  cnt_clr=1 sets all to 0, overrides increment that cycle.
- Latency: instruction accepted at stage 1 on cycle N appears in stage 4 at N+3 with no stalls.
- Outputs are registered except pc_enable and br_resolve.

Test Plan:
- Reset then fetch_valid=1 with words 0x0021,0x0041,0x0061 on consecutive cycles -> 0x0021 in inst_ipipe[4] on cycle 4, valid_ipipe=4'b1111 by cycle 4, retired_cnt=1 at cycle 5.
- hazard_hold=1 for 2 cycles with valid stage 2 -> stages 1,2 unchanged, two bubbles (0x0000, valid 0) enter stage 3, pc_enable=0 both cycles, stall_cnt=2.
- Branch 0x0008 fetched -> next cycle stage 1 bubble, FSM BR_WAIT; two cycles later br_resolve=1, pc_enable=1, branch_cnt=1, FSM RUN.
- mem_busy=1 for 3 cycles while branch in stage 3 -> all pipe registers frozen, br_resolve=0, stall_cnt +3; resolves on first cycle after mem_busy drops.
- retired_cnt preloaded to all-ones via run with CNT_W=4, one more retirement -> counter 0; cnt_clr with retirement same cycle -> 0.
- Assert reset low mid-HOLD with branch in flight -> all outputs 0 immediately (asynchronously), FSM RUN after release.
